// File: rtl/button_poll_master.sv
// rtl/button_poll_master.sv - Avalon-MM poller for a button PIO with debounce and press/release pulses
// Optional BUTTON_POLL_IRQ_EN adds sticky press capture (edge_capture) with irq/irq_ack.
module button_poll_master #(
   parameter int         WIDTH        = 4,
   parameter int         POLL_DIV     = 50000,
   parameter int         DEBOUNCE_CNT = 4,
   parameter logic [1:0] PIO_ADDR     = 2'd0,
   parameter bit         ACTIVE_LOW   = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   output logic [1:0]       avm_address,
   output logic             avm_read,
   input  logic             avm_waitrequest,
   input  logic [31:0]      avm_readdata,
   output logic [WIDTH-1:0] buttons,
   output logic [WIDTH-1:0] press,
   output logic [WIDTH-1:0] release_evt,
`ifdef BUTTON_POLL_IRQ_EN
   output logic             irq,
   input  logic             irq_ack,
   output logic [WIDTH-1:0] edge_capture,
`endif
   output logic             busy
);

   localparam int TW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int CW = $clog2(DEBOUNCE_CNT + 1);
   localparam logic [WIDTH-1:0] IDLE    = ACTIVE_LOW ? '1 : '0;
   localparam logic [TW-1:0]    RELOAD  = TW'(POLL_DIV - 1);
   localparam logic [CW-1:0]    CNT_MAX = CW'(DEBOUNCE_CNT);

   typedef enum logic [1:0] {S_WAIT, S_READ, S_DATA} state_t;

   state_t            state, state_nxt;
   logic [TW-1:0]     timer, timer_nxt;
   logic [WIDTH-1:0]  sample;
   logic [WIDTH-1:0]  last_sample;
   logic [WIDTH-1:0]  accept;
   logic [CW-1:0]     cnt     [WIDTH];
   logic [CW-1:0]     cnt_upd [WIDTH];
   logic              unused_readdata;

   assign avm_address     = PIO_ADDR;
   assign sample          = avm_readdata[WIDTH-1:0];
   assign unused_readdata = ^avm_readdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_WAIT;
         timer <= RELOAD;
      end else begin
         state <= state_nxt;
         timer <= timer_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      timer_nxt = timer;
      avm_read  = 1'b0;
      busy      = 1'b0;
      case (state)
         S_WAIT: begin
            if (timer == '0) begin
               timer_nxt = RELOAD;
               state_nxt = S_READ;
            end else begin
               timer_nxt = timer - TW'(1);
            end
         end
         S_READ: begin
            avm_read = 1'b1;
            busy     = 1'b1;
            if (!avm_waitrequest) state_nxt = S_DATA;
         end
         S_DATA: begin
            busy      = 1'b1;
            state_nxt = S_WAIT;
         end
         default: state_nxt = S_WAIT;
      endcase
   end

   // A bit's level is accepted on the sample that brings its run length to DEBOUNCE_CNT.
   always_comb begin
      accept = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (sample[i] == last_sample[i])
            cnt_upd[i] = (cnt[i] >= CNT_MAX) ? CNT_MAX : cnt[i] + CW'(1);
         else
            cnt_upd[i] = CW'(1);
         accept[i] = (cnt_upd[i] == CNT_MAX) && (sample[i] != buttons[i]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_sample <= IDLE;
         buttons     <= IDLE;
         press       <= '0;
         release_evt <= '0;
         for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      end else begin
         press       <= '0;
         release_evt <= '0;
         if (state == S_DATA) begin
            last_sample <= sample;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= cnt_upd[i];
            buttons     <= (buttons & ~accept) | (sample & accept);
            press       <= accept & (sample ^ IDLE);
            release_evt <= accept & ~(sample ^ IDLE);
         end
      end
   end

`ifdef BUTTON_POLL_IRQ_EN
   // A press coinciding with irq_ack survives the clear.
   always_ff @(posedge clk) begin
      if (reset)
         edge_capture <= '0;
      else if (irq_ack)
         edge_capture <= press;
      else
         edge_capture <= edge_capture | press;
   end

   assign irq = |edge_capture;
`endif

endmodule

// File: tb/tb_button_poll_master.sv
// tb/tb_button_poll_master.sv - scoreboard bench for button_poll_master
// Covers BUTTON_POLL_IRQ_EN checks when that macro is defined.
module tb_button_poll_master;

   localparam int W  = 4;
   localparam int PD = 4;
   localparam int DB = 3;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   avm_address;
   logic         avm_read;
   logic         avm_waitrequest;
   logic [31:0]  avm_readdata;
   logic [W-1:0] buttons;
   logic [W-1:0] press;
   logic [W-1:0] release_evt;
   logic         busy;
`ifdef BUTTON_POLL_IRQ_EN
   logic         irq;
   logic         irq_ack;
   logic [W-1:0] edge_capture;
`endif

   button_poll_master #(
      .WIDTH(W), .POLL_DIV(PD), .DEBOUNCE_CNT(DB), .PIO_ADDR(2'd0), .ACTIVE_LOW(1'b1)
   ) dut (
      .clk(clk),
      .reset(reset),
      .avm_address(avm_address),
      .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest),
      .avm_readdata(avm_readdata),
      .buttons(buttons),
      .press(press),
      .release_evt(release_evt),
`ifdef BUTTON_POLL_IRQ_EN
      .irq(irq),
      .irq_ack(irq_ack),
      .edge_capture(edge_capture),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] btn;
      logic [W-1:0] prs;
      logic [W-1:0] rel;
   } exp_t;

   exp_t         sb_q[$];
   int           vectors     = 0;
   int           miscompares = 0;
   logic [W-1:0] m_btn;
   logic [W-1:0] m_last;
   int           m_run [W];

   task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_btn  = 4'hF;
      m_last = 4'hF;
      for (int i = 0; i < W; i++) m_run[i] = 0;
   endtask

   // Reference debounce: length of the current run of equal samples, capped at DB.
   task automatic model_sample(input logic [W-1:0] s);
      exp_t e;
      e.prs = '0;
      e.rel = '0;
      for (int i = 0; i < W; i++) begin
         if (s[i] == m_last[i]) m_run[i] = (m_run[i] < DB) ? m_run[i] + 1 : DB;
         else                   m_run[i] = 1;
         if (m_run[i] == DB && s[i] != m_btn[i]) begin
            m_btn[i] = s[i];
            if (s[i] == 1'b0) e.prs[i] = 1'b1;
            else              e.rel[i] = 1'b1;
         end
      end
      m_last = s;
      e.btn  = m_btn;
      sb_q.push_back(e);
   endtask

   task automatic wait_read(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!avm_read && n < 20);
   endtask

   task automatic poll(input logic [W-1:0] d, input int wt, input int gap);
      int   n;
      exp_t e;
      wait_read(n);
      check_vec("poll_gap", n, gap);
      check_vec("read_addr", avm_address, 0);
      check_vec("busy_read", busy, 1);
      avm_readdata    = {28'($urandom), ~d};
      avm_waitrequest = (wt > 0);
      for (int k = 0; k < wt; k++) begin
         @(negedge clk);
         check_vec("read_hold", avm_read, 1);
         check_vec("addr_hold", avm_address, 0);
         if (k == wt - 1) avm_waitrequest = 1'b0;
      end
      @(negedge clk);
      check_vec("data_read_low", avm_read, 0);
      check_vec("busy_data", busy, 1);
      avm_readdata = {28'($urandom), d};
      model_sample(d);
      @(negedge clk);
      avm_readdata = {28'($urandom), ~d};
      check_vec("busy_wait", busy, 0);
      if (sb_q.size() == 0) begin
         check_vec("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         check_vec("buttons", buttons, e.btn);
         check_vec("press", press, e.prs);
         check_vec("release", release_evt, e.rel);
      end
      @(negedge clk);
      check_vec("press_1cyc", press, 0);
      check_vec("release_1cyc", release_evt, 0);
   endtask

   initial begin
      int n;
      int gap_after_ack;
      reset           = 1'b1;
      avm_waitrequest = 1'b0;
      avm_readdata    = '0;
`ifdef BUTTON_POLL_IRQ_EN
      irq_ack         = 1'b0;
      gap_after_ack   = 2;
`else
      gap_after_ack   = 3;
`endif
      model_reset();
      repeat (3) @(negedge clk);
      check_vec("rst_read", avm_read, 0);
      check_vec("rst_busy", busy, 0);
      check_vec("rst_buttons", buttons, 4'hF);
      check_vec("rst_press", press, 0);
      check_vec("rst_release", release_evt, 0);
      reset = 1'b0;

      poll(4'hF, 0, 4);
      poll(4'hF, 3, 3);
      repeat (3) poll(4'hE, 0, 3);
`ifdef BUTTON_POLL_IRQ_EN
      check_vec("edge_cap_set", edge_capture, 4'h1);
      check_vec("irq_set", irq, 1);
`endif
      repeat (3) poll(4'hF, 0, 3);
`ifdef BUTTON_POLL_IRQ_EN
      check_vec("edge_cap_hold", edge_capture, 4'h1);
      irq_ack = 1'b1;
      @(negedge clk);
      irq_ack = 1'b0;
      check_vec("edge_cap_clr", edge_capture, 0);
      check_vec("irq_clr", irq, 0);
`endif
      poll(4'hE, 0, gap_after_ack);
      poll(4'hF, 0, 3);
      poll(4'hE, 0, 3);
      poll(4'hE, 0, 3);
      poll(4'hE, 0, 3);

      wait_read(n);
      check_vec("pre_rst_gap", n, 3);
      avm_waitrequest = 1'b1;
      @(negedge clk);
      check_vec("stall_read", avm_read, 1);
      reset = 1'b1;
      @(negedge clk);
      check_vec("midrst_read", avm_read, 0);
      check_vec("midrst_busy", busy, 0);
      check_vec("midrst_buttons", buttons, 4'hF);
      check_vec("midrst_press", press, 0);
      check_vec("midrst_release", release_evt, 0);
`ifdef BUTTON_POLL_IRQ_EN
      check_vec("midrst_edge_cap", edge_capture, 0);
`endif
      model_reset();
      avm_waitrequest = 1'b0;
      reset = 1'b0;
      poll(4'hF, 0, 4);
      poll(4'hE, 0, 3);

      check_vec("sb_drained", sb_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/button_poll_master.md
Name: button_poll_master

Overview:
- Avalon-MM master that periodically reads a push-button input PIO slave at a fixed address.
- Debounces the sampled button bits and emits one-cycle press and release event pulses for the HPS-less control path.
- Replaces software polling of the button PIO.
- Sits on the lightweight fabric interconnect, directly in front of the button PIO slave.

Parameters:
- WIDTH, 4: number of button bits taken from readdata[WIDTH-1:0].
- POLL_DIV, 50000: WAIT-state cycles between reads; must be >=1.
- DEBOUNCE_CNT, 4: consecutive identical samples needed to accept a new level; must be >=1.
- PIO_ADDR, 0: 2-bit word address driven on avm_address.
- ACTIVE_LOW, 1: 1 = button pressed reads as 0 (DE1-SoC KEY); 0 = pressed reads as 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- avm_address  out  2  Avalon-MM address, constant PIO_ADDR
- avm_read  out  1  Avalon-MM read request
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  32  read data, valid exactly 1 cycle after read acceptance
- buttons  out  WIDTH  debounced button levels, raw polarity
- press  out  WIDTH  one-cycle pulse per bit on debounced idle->pressed transition
- release  out  WIDTH  one-cycle pulse per bit on debounced pressed->idle transition
- busy  out  1  high in READ and DATA states

Behaviour:
- Interface fixed: one clock, clk; reset is synchronous and active-high, port reset. All state changes on posedge clk.
- Idle level: IDLE = all ones if ACTIVE_LOW=1, else all zeros.
- Reset values:
  - Outputs: avm_read=0, buttons=IDLE, press=0, release=0, busy=0.
  - Internal: FSM=WAIT, timer=POLL_DIV-1, last_sample=IDLE, per-bit stable counters=0.
- FSM:
  - WAIT: timer decrements each cycle. At timer==0, reload POLL_DIV-1 and go to READ. WAIT therefore lasts exactly POLL_DIV cycles.
  - READ: avm_read=1, avm_address=PIO_ADDR, both held stable while avm_waitrequest=1. The cycle with avm_waitrequest=0 is acceptance; go to DATA.
  - DATA: avm_read=0. Sample s=avm_readdata[WIDTH-1:0]; fixed read latency of 1 cycle. Update debounce, then go to WAIT.
  - Exactly one read per poll. No pipelined or back-to-back reads.
- Debounce, per bit i, evaluated only in DATA:
  - If s[i]==last_sample[i], cnt[i]=min(cnt[i]+1, DEBOUNCE_CNT); else cnt[i]=1. last_sample[i]<=s[i].
  - When the new cnt[i]==DEBOUNCE_CNT and s[i]!=buttons[i], buttons[i]<=s[i] on the same edge.
  - press[i] or release[i] asserts for the one following cycle, according to direction and ACTIVE_LOW.
  - With DEBOUNCE_CNT=1, every changed sample is accepted immediately.
- press/release are registered, high for exactly 1 cycle, never both high on the same bit. Multiple bits may pulse in the same cycle.
- Upper readdata bits are ignored.
- Reset mid-operation: reset in READ drops avm_read on the next edge regardless of waitrequest. Everything returns to reset values; no event pulses fire.
- Timer is WIDTH-independent, sized ceil(log2(POLL_DIV)); wraps only via reload, never underflows.

Optional Feature:
- Macro: BUTTON_POLL_IRQ_EN.
- Defined:
  - Adds ports irq (out 1), irq_ack (in 1), edge_capture (out WIDTH).
  - edge_capture[i] is set by press[i] and is sticky. irq = |edge_capture, registered-free combinational OR.
  - irq_ack=1 clears all bits on the next edge. If press[i] and irq_ack coincide, the bit stays set (set wins).
  - Reset clears edge_capture.
- Undefined: these ports and this logic are absent. All other behaviour is identical.

Test Plan (WIDTH=4, POLL_DIV=4, DEBOUNCE_CNT=3, ACTIVE_LOW=1, waitrequest=0 unless stated):
- Release reset -> buttons=4'hF, press=release=0, avm_read first high on 5th cycle after reset deassert, high exactly 1 cycle; avm_address=0.
- avm_waitrequest=1 for 3 cycles in READ -> avm_read and avm_address stable for 4 cycles, busy high through DATA; one sample taken, from the cycle after waitrequest falls.
- readdata[3:0]=4'hE for 3 polls -> after 3rd DATA cycle buttons=4'hE, press=4'h1 for exactly one cycle, release=0.
- Bounce sequence E,F,E,E,E -> no event until 5th poll, then press=4'h1 once.
- From buttons=4'hE, readdata=4'hF for 3 polls -> buttons=4'hF, release=4'h1 one cycle, press=0. With BUTTON_POLL_IRQ_EN: earlier press left edge_capture=4'h1 and irq=1; irq_ack pulse clears both.
- Assert reset in READ with waitrequest=1 -> avm_read=0 next cycle, buttons=4'hF, no pulses; normal poll resumes POLL_DIV cycles after deassert.
